// File: rtl/gate_accumulator.sv
// Bitwise fold accumulator: AND/OR/XOR over a beat stream, with optional
// inversion, held in DONE until the consumer takes the answer.
module gate_accumulator #(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 16,
    localparam int CW     = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] answer,
    output logic             answer_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    op_count,
    output logic             overflow
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ACCUM = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [2:0]       mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             at_max;

    function automatic logic [WIDTH-1:0] fold(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (op)
            2'b00:   fold = a & b;
            2'b10:   fold = a ^ b;
            default: fold = a | b;
        endcase
    endfunction

    // in_ready depends on state only, never on in_valid
    assign in_ready     = (state_q != DONE);
    assign accept       = in_valid && in_ready;
    assign at_max       = (cnt_q == CW'(MAX_OPS - 1));
    assign answer_valid = (state_q == DONE);
    assign answer       = answer_valid ? (acc_q ^ {WIDTH{mode_q[2]}}) : '0;
    assign op_count     = cnt_q;
    assign overflow     = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    mode_d  = mode;
                    cnt_d   = CW'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = fold(mode_q[1:0], acc_q, in_data);
                    cnt_d = cnt_q + CW'(1);
                    if (in_last) begin
                        state_d = DONE;
                    end else if (at_max) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
